arb_req_bank: RTL and testbench
===============================

Name: arb_req_bank

Overview:
Requester-side companion to the round-robin arbiter. It holds a small per-channel FIFO of pending transactions and drives one request line per channel into the arbiter. It consumes the arbiter's one-hot grant, pops the granted channel's head entry, and presents it as a single registered output beat tagged with the channel id. A sticky error flag reports protocol-illegal grants.

Parameters:
N, 4, number of requester channels (matches arbiter N)
DEPTH, 4, entries per channel FIFO; power of 2, >= 2
W, 8, payload width per entry

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
en  input  1  block enable; gates req and grant consumption
in_valid  input  N  per-channel push strobe
in_ready  output  N  per-channel FIFO not full
in_data  input  N*W  per-channel payload; channel i at bits [i*W +: W]
req  output  N  request lines to arbiter
gnt  input  N  one-hot grant from arbiter
any_gnt  input  1  arbiter any-grant indicator
out_valid  output  1  granted beat valid, one cycle
out_id  output  $clog2(N)  channel index of granted beat
out_data  output  W  payload of granted beat
err_gnt  output  1  sticky protocol error
starve  output  N  per-channel starvation flag (STARVE_MON_EN only; tied 0 otherwise)

Behaviour:
- Reset: when reset = 0 at a clk edge, all FIFO pointers and counts clear to 0, and out_valid, out_id, out_data, err_gnt and starve clear to 0. Consequences: in_ready = all 1s; req = 0.
- FIFO per channel:
  - count range 0..DEPTH.
  - in_ready[i] = (count[i] != DEPTH), combinational from registered count. No same-cycle pop bypass.
  - Push when in_valid[i] & in_ready[i]; data is written at the write pointer.
  - Pointers wrap modulo DEPTH.
  - Push while full is dropped: nothing is written and count is unchanged.
- Requests: req[i] = en & (count[i] != 0), combinational from registers. req is held until the channel is granted or empty; it is never withdrawn otherwise.
- Grant acceptance, evaluated each cycle:
  - legal = en & gnt is one-hot & (gnt & req) == gnt & any_gnt == 1.
  - Legal grant on channel k: pop channel k's head.
  - Next cycle: out_valid = 1, out_id = k, out_data = the popped head.
- Output latency and hold: 1 cycle from grant to out_valid. out_valid is a single-cycle pulse per grant. out_id and out_data hold their last values when out_valid = 0. No backpressure; the consumer must accept every beat.
- Simultaneous push and pop on the same channel: both happen and count is unchanged. This includes count = DEPTH, because the pop frees no slot within the cycle, so in_ready stays 0. It also includes count = 1, where the new entry becomes head on the next cycle.
- Error detection: err_gnt is set and stays 1 until reset, if en = 1 and any of these holds:
  - gnt has more than one bit set;
  - gnt is nonzero on a channel with req = 0;
  - any_gnt != |gnt.
  On an illegal cycle, no pop occurs on any channel.
- en = 0:
  - req = 0.
  - gnt and any_gnt are ignored: no pop, no error check.
  - Pushes are still accepted.
  - An out_valid already scheduled from the previous cycle is still emitted.
- Reset mid-operation: all queued entries are discarded. A pending out_valid is cancelled, so out_valid = 0 on the cycle after the reset edge.

Optional Feature:
- Macro: ARB_REQ_BANK_STARVE_MON_EN. When it is defined:
  - Parameter STARVE_LIMIT, default 15, is active, with one per-channel wait counter of width $clog2(STARVE_LIMIT+1).
  - The counter increments each cycle req[i] = 1 without a legal grant to i, and saturates at STARVE_LIMIT.
  - The counter clears on a legal grant to i or when req[i] = 0.
  - starve[i] = 1 while the counter == STARVE_LIMIT. It is registered, with reset value 0.
- Without the macro: no counters are built and starve is tied to 0.

Test Plan:
1. Reset, then push 0xA5 on channel 2 -> next cycle req = 4'b0100. Drive gnt = 4'b0100, any_gnt = 1 -> next cycle out_valid = 1, out_id = 2, out_data = 0xA5; then req = 0.
2. Fill channel 0 with 0x01..0x04 -> in_ready[0] = 0. Fifth push is dropped. Four grants to channel 0 -> out_data 0x01, 0x02, 0x03, 0x04 in order; then in_ready[0] = 1.
3. Channel 1 full. Push 0x55 and grant channel 1 in the same cycle -> count stays 4, in_ready[1] stays 0, 0x55 emerges after the 4th pop.
4. Channel 3 has req = 1. Drive gnt = 4'b1010 -> no pop, out_valid = 0, err_gnt = 1 from the next cycle, held through later legal traffic until reset.
5. en = 0 with channels 0 and 1 non-empty -> req = 0. A gnt = 4'b0001 is ignored: count unchanged, err_gnt = 0. Raise en -> req = 4'b0011.
6. With the macro defined, STARVE_LIMIT = 15: hold req[0] for 15 cycles without a grant -> starve[0] = 1. Grant channel 0 -> starve[0] = 0 next cycle. Without the macro, starve stays 4'b0000.

Source files
------------

// File: rtl/arb_req_bank.sv
// arb_req_bank: requester-side bank for a round-robin arbiter.
// Holds a small FIFO of pending payloads per channel, raises one request line
// per non-empty channel, pops the head of the granted channel and presents it
// as a single registered beat tagged with the channel index.
// Illegal grants (multi-hot, grant to a non-requesting channel, or any_gnt
// disagreeing with |gnt) set a sticky err_gnt and pop nothing.
//
// Optional feature: define ARB_REQ_BANK_STARVE_MON_EN to build per-channel
// wait counters that drive starve[]; without it starve is tied to zero.
//
// Handshake: a push on channel i happens when in_valid[i] is high and the
// FIFO has room (in_ready[i]), or when the same channel is legally granted in
// that cycle, so a full FIFO accepts a new entry while its head leaves. The
// output side has no backpressure: out_valid is a one-cycle pulse per legal
// grant and the consumer must take every beat.
module arb_req_bank #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int W     = 8
`ifdef ARB_REQ_BANK_STARVE_MON_EN
  ,
  parameter int STARVE_LIMIT = 15
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         req,
  input  logic [N-1:0]         gnt,
  input  logic                 any_gnt,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_id,
  output logic [W-1:0]         out_data,
  output logic                 err_gnt,
  output logic [N-1:0]         starve
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(N);

  // Per-channel FIFO state
  logic [CW-1:0] count_q  [N];
  logic [CW-1:0] count_d  [N];
  logic [PW-1:0] wr_ptr_q [N];
  logic [PW-1:0] wr_ptr_d [N];
  logic [PW-1:0] rd_ptr_q [N];
  logic [PW-1:0] rd_ptr_d [N];
  logic [W-1:0]  mem_q    [N][DEPTH];

  // Output beat and error registers
  logic          out_valid_q;
  logic [IW-1:0] out_id_q;
  logic [W-1:0]  out_data_q;
  logic          err_gnt_q;

  // Grant qualification
  logic          gnt_multi;
  logic          gnt_onehot;
  logic          gnt_covered;
  logic          gnt_any_ok;
  logic          gnt_legal;
  logic          gnt_illegal;
  logic [IW-1:0] gnt_idx;
  logic [W-1:0]  head_data;

  logic [N-1:0]  push;
  logic [N-1:0]  pop;

  // Status outputs come straight from the registered counts.
  always_comb begin
    in_ready = '0;
    req      = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = (count_q[i] != CW'(DEPTH));
      req[i]      = en & (count_q[i] != '0);
    end
  end

  assign gnt_multi   = ((gnt & (gnt - N'(1))) != '0);
  assign gnt_onehot  = (gnt != '0) & ~gnt_multi;
  assign gnt_covered = ((gnt & ~req) == '0);
  assign gnt_any_ok  = (any_gnt == (|gnt));
  assign gnt_legal   = en & gnt_onehot & gnt_covered & any_gnt;
  assign gnt_illegal = en & (gnt_multi | ~gnt_covered | ~gnt_any_ok);

  // Encode the one-hot grant to a channel index and fetch that channel's head.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = IW'(i);
    end
    head_data = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
  end

  // Push/pop decisions; a full channel being popped still takes a new entry
  // because the slot it writes is the head slot being read out this cycle.
  always_comb begin
    pop  = gnt_legal ? gnt : '0;
    push = '0;
    for (int i = 0; i < N; i++) begin
      push[i] = in_valid[i] & (in_ready[i] | pop[i]);
    end
  end

  // Next-state for counts and pointers; pointers wrap naturally at DEPTH.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      count_d[i]  = count_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // FIFO control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!reset) begin
        count_q[i]  <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end else begin
        count_q[i]  <= count_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*W +: W];
    end
  end

  // Registered output beat: pulse valid, hold id/data between beats.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= gnt_legal;
      if (gnt_legal) begin
        out_id_q   <= gnt_idx;
        out_data_q <= head_data;
      end
    end
  end

  // Sticky grant-protocol error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_gnt_q <= 1'b0;
    end else if (gnt_illegal) begin
      err_gnt_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign err_gnt   = err_gnt_q;

`ifdef ARB_REQ_BANK_STARVE_MON_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] wait_q [N];
  logic [SW-1:0] wait_d [N];
  logic [N-1:0]  starve_q;
  logic [N-1:0]  starve_d;

  // Count cycles a channel requests without being served, saturating.
  always_comb begin
    starve_d = '0;
    for (int i = 0; i < N; i++) begin
      wait_d[i] = wait_q[i];
      if (!req[i] || pop[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != SW'(STARVE_LIMIT)) begin
        wait_d[i] = wait_q[i] + SW'(1);
      end
      starve_d[i] = (wait_d[i] == SW'(STARVE_LIMIT));
    end
  end

  // Wait counters and registered starvation flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
      for (int i = 0; i < N; i++) wait_q[i] <= '0;
    end else begin
      starve_q <= starve_d;
      for (int i = 0; i < N; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign starve = starve_q;
`else
  assign starve = '0;
`endif

endmodule

// File: tb/tb_arb_req_bank.sv
// Testbench for arb_req_bank: directed vectors, expected beats queued at grant
// time and checked by an independent output monitor.
module tb_arb_req_bank;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

`ifdef ARB_REQ_BANK_STARVE_MON_EN
  localparam logic [N-1:0] STARVE_HIT = 4'b0001;
`else
  localparam logic [N-1:0] STARVE_HIT = 4'b0000;
`endif

  logic           clk;
  logic           reset;
  logic           en;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           any_gnt;
  logic           out_valid;
  logic [IW-1:0]  out_id;
  logic [W-1:0]   out_data;
  logic           err_gnt;
  logic [N-1:0]   starve;

  int checks = 0;
  int errors = 0;
  logic [IW+W-1:0] exp_q[$];

  arb_req_bank dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .gnt       (gnt),
    .any_gnt   (any_gnt),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_data  (out_data),
    .err_gnt   (err_gnt),
    .starve    (starve)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = '0;
    gnt      = '0;
    any_gnt  = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  // Driver tasks
  task automatic push(input int ch, input logic [W-1:0] d);
    in_valid            = '0;
    in_valid[ch]        = 1'b1;
    in_data[ch*W +: W]  = d;
    cycle();
    in_valid = '0;
  endtask

  task automatic grant(input int ch, input logic [W-1:0] d);
    logic [IW-1:0] id;
    id        = IW'(ch);
    gnt       = '0;
    gnt[ch]   = 1'b1;
    any_gnt   = 1'b1;
    exp_q.push_back({id, d});
    cycle();
    gnt     = '0;
    any_gnt = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    logic [IW+W-1:0] exp;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got id=%0d data=%h, required no beat", out_id, out_data);
        end else begin
          exp = exp_q.pop_front();
          if ({out_id, out_data} !== exp) begin
            errors++;
            $display("FAIL beat: got id=%0d data=%h, required id=%0d data=%h",
                     out_id, out_data, exp[IW+W-1:W], exp[W-1:0]);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    en       = 1'b0;
    in_data  = '0;
    in_valid = '0;
    gnt      = '0;
    any_gnt  = 1'b0;
    reset    = 1'b0;
    do_reset();

    check("rst_in_ready", 32'(in_ready), 32'hF);
    check("rst_req", 32'(req), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_id", 32'(out_id), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_err_gnt", 32'(err_gnt), 32'h0);
    check("rst_starve", 32'(starve), 32'h0);

    en = 1'b1;

    // 1: single push and grant on channel 2
    push(2, 8'hA5);
    check("t1_req", 32'(req), 32'h4);
    grant(2, 8'hA5);
    check("t1_req_after", 32'(req), 32'h0);

    // 2: fill channel 0, drop fifth push, drain in order
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    push(0, 8'h04);
    check("t2_full_ready", 32'(in_ready), 32'hE);
    push(0, 8'h05);
    check("t2_drop_ready", 32'(in_ready), 32'hE);
    check("t2_req", 32'(req), 32'h1);
    grant(0, 8'h01);
    grant(0, 8'h02);
    grant(0, 8'h03);
    grant(0, 8'h04);
    check("t2_ready_after", 32'(in_ready), 32'hF);
    check("t2_req_after", 32'(req), 32'h0);

    // 3: push and pop together on a full channel 1
    push(1, 8'h11);
    push(1, 8'h12);
    push(1, 8'h13);
    push(1, 8'h14);
    in_valid              = 4'b0010;
    in_data[1*W +: W]     = 8'h55;
    grant(1, 8'h11);
    in_valid = '0;
    check("t3_still_full", 32'(in_ready), 32'hD);
    grant(1, 8'h12);
    check("t3_room", 32'(in_ready), 32'hF);
    grant(1, 8'h13);
    grant(1, 8'h14);
    check("t3_req_last", 32'(req), 32'h2);
    grant(1, 8'h55);
    check("t3_req_after", 32'(req), 32'h0);

    // 4: illegal multi-hot grant, sticky error
    push(3, 8'h77);
    check("t4_req", 32'(req), 32'h8);
    gnt     = 4'b1010;
    any_gnt = 1'b1;
    cycle();
    gnt     = '0;
    any_gnt = 1'b0;
    check("t4_err", 32'(err_gnt), 32'h1);
    check("t4_no_pop", 32'(req), 32'h8);
    grant(3, 8'h77);
    check("t4_err_sticky", 32'(err_gnt), 32'h1);
    check("t4_req_after", 32'(req), 32'h0);
    do_reset();
    check("t4_err_cleared", 32'(err_gnt), 32'h0);

    // 4b: any_gnt disagrees with a one-hot grant
    push(0, 8'h42);
    gnt     = 4'b0001;
    any_gnt = 1'b0;
    cycle();
    gnt = '0;
    check("t4b_err", 32'(err_gnt), 32'h1);
    check("t4b_no_pop", 32'(req), 32'h1);
    do_reset();

    // 5: en low ignores grants but accepts pushes
    en = 1'b0;
    push(0, 8'h21);
    push(1, 8'h31);
    check("t5_req_off", 32'(req), 32'h0);
    gnt     = 4'b0001;
    any_gnt = 1'b1;
    cycle();
    gnt     = '0;
    any_gnt = 1'b0;
    check("t5_err", 32'(err_gnt), 32'h0);
    en = 1'b1;
    #1;
    check("t5_req_on", 32'(req), 32'h3);
    grant(0, 8'h21);
    en = 1'b0;
    cycle();
    en = 1'b1;
    grant(1, 8'h31);
    check("t5_req_after", 32'(req), 32'h0);

    // Reset mid-operation cancels a pending beat and discards entries
    push(2, 8'h99);
    reset   = 1'b0;
    gnt     = 4'b0100;
    any_gnt = 1'b1;
    cycle();
    gnt     = '0;
    any_gnt = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'h0);
    check("rst_mid_ready", 32'(in_ready), 32'hF);
    check("rst_mid_req", 32'(req), 32'h0);
    reset = 1'b1;
    cycle();

    // 6: starvation monitor on channel 0
    push(0, 8'h3C);
    repeat (14) cycle();
    check("t6_starve_before", 32'(starve), 32'h0);
    cycle();
    check("t6_starve_hit", 32'(starve), 32'(STARVE_HIT));
    grant(0, 8'h3C);
    check("t6_starve_clear", 32'(starve), 32'h0);

    repeat (3) cycle();
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
